// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package ram_arb_pkg;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic P_CPU  = 1'b0;
   localparam logic P_LOAD = 1'b1;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way grant selection. r_prio is the port that wins a tie; it moves to
// the loser of each decision so back-to-back ties alternate.
module rr_arbiter_2
   import ram_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic       o_winner,
   output logic       o_any_req
);
   logic r_prio;
   logic w_win;

   always_comb begin
      w_win = i_req[1];
      if (i_req == 2'b11) w_win = RR_EN ? r_prio : P_CPU;
   end

   assign o_winner  = w_win;
   assign o_any_req = |i_req;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)                     r_prio <= P_CPU;
      else if (i_advance && o_any_req) r_prio <= ~w_win;
   end
endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto the single-port data RAM: grant/issue,
// then an extra cycle for reads while the RAM registers its output.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_dataIn,
   output logic              ram_we,
   output logic              ram_rd,
   input  logic [DATA_W-1:0] ram_dataOut
);
   state_t              r_state, w_state_nxt;
   logic                r_port, r_we;
   logic                w_winner, w_any_req, w_advance;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;

   assign w_advance = (r_state == IDLE);

   rr_arbiter_2 #(.RR_EN(RR_EN)) u_rr (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_req     ({req1, req0}),
      .i_advance (w_advance),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   assign w_we    = w_winner ? we1    : we0;
   assign w_addr  = w_winner ? addr1  : addr0;
   assign w_wdata = w_winner ? wdata1 : wdata0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = r_we ? IDLE : WAIT;
         WAIT:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Pulses default low every cycle; address/data and rdata hold between accesses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         ram_address <= '0;
         ram_dataIn  <= '0;
         ram_we      <= 1'b0;
         ram_rd      <= 1'b0;
         r_port      <= P_CPU;
         r_we        <= 1'b0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         ram_we  <= 1'b0;
         ram_rd  <= 1'b0;
         if (r_state == IDLE && w_any_req) begin
            r_port      <= w_winner;
            r_we        <= w_we;
            ram_address <= w_addr;
            ram_dataIn  <= w_wdata;
            ram_we      <= w_we;
            ram_rd      <= ~w_we;
            gnt0        <= (w_winner == P_CPU);
            gnt1        <= (w_winner == P_LOAD);
         end else if (r_state == WAIT) begin
            if (r_port == P_LOAD) begin
               rdata1  <= ram_dataOut;
               rvalid1 <= 1'b1;
            end else begin
               rdata0  <= ram_dataOut;
               rvalid0 <= 1'b1;
            end
         end
      end
   end
endmodule
